// File: rtl/collate_decode_fifo_pkg.sv
// Shared types for the collate->decode instruction FIFO.
// The optional COLLATE_FIFO_BYPASS_EN path lives in collate_decode_fifo.sv.
package collate_decode_fifo_pkg;
  localparam int WFID_W  = 6;
  localparam int INSTR_W = 64;
  localparam int PC_W    = 32;

  typedef struct packed {
    logic [WFID_W-1:0]  wfid;
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
    logic               is_long;
    logic               killed;
  } entry_t;
endpackage

// File: rtl/collate_decode_fifo_ptr.sv
// Pointer/count bookkeeping for the collate FIFO: wrap, full, empty, registered almost-full.
module collate_fifo_ptr
  import collate_decode_fifo_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int AF_MARGIN = 1,
  parameter int CNT_W     = 3,
  localparam int PTR_W    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  output logic [PTR_W-1:0] rd_ptr,
  output logic [PTR_W-1:0] wr_ptr,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty,
  output logic             almost_full
);
  localparam logic [CNT_W-1:0] AF_TH = CNT_W'(DEPTH - AF_MARGIN);

  logic [PTR_W-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             af_q, af_d;

  // DEPTH is a power of two, so pointers wrap naturally.
  always_comb begin
    rd_d    = rd_q;
    wr_d    = wr_q;
    count_d = count_q;
    if (push) wr_d = wr_q + 1'b1;
    if (pop)  rd_d = rd_q + 1'b1;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
    af_d = (count_d >= AF_TH);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
      af_q    <= 1'b0;
    end else begin
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      count_q <= count_d;
      af_q    <= af_d;
    end
  end

  assign rd_ptr      = rd_q;
  assign wr_ptr      = wr_q;
  assign count       = count_q;
  assign full        = (count_q == CNT_W'(DEPTH));
  assign empty       = (count_q == '0);
  assign almost_full = af_q;
endmodule

// File: rtl/collate_decode_fifo.sv
// Collate->decode instruction FIFO with per-wavefront kill and sticky overflow.
// Define COLLATE_FIFO_BYPASS_EN for a zero-latency path through an empty FIFO.
module collate_decode_fifo
  import collate_decode_fifo_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int AF_MARGIN = 1,
  parameter int CNT_W     = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [WFID_W-1:0]  in_wfid,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [PC_W-1:0]    in_pc,
  input  logic               in_long,
  input  logic               kill_valid,
  input  logic [WFID_W-1:0]  kill_wfid,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WFID_W-1:0]  out_wfid,
  output logic [INSTR_W-1:0] out_instr,
  output logic [PC_W-1:0]    out_pc,
  output logic               out_long,
  output logic [CNT_W-1:0]   out_count,
  output logic               out_almost_full,
  output logic               out_overflow
);
  localparam int PTR_W = $clog2(DEPTH);

  entry_t           mem_q [DEPTH];
  entry_t           mem_d [DEPTH];
  entry_t           head, in_ent;
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [CNT_W-1:0] count;
  logic             full, empty, almost_full;
  logic             push, pop, in_kill, bypass;
  logic             ovf_q, ovf_d;

  collate_fifo_ptr #(.DEPTH(DEPTH), .AF_MARGIN(AF_MARGIN), .CNT_W(CNT_W)) u_ptr (
    .clk        (clk),
    .rst_n      (rst),
    .push       (push),
    .pop        (pop),
    .rd_ptr     (rd_ptr),
    .wr_ptr     (wr_ptr),
    .count      (count),
    .full       (full),
    .empty      (empty),
    .almost_full(almost_full)
  );

  assign head    = mem_q[rd_ptr];
  assign in_kill = kill_valid && (in_wfid == kill_wfid);
  assign in_ent  = '{wfid: in_wfid, instr: in_instr, pc: in_pc,
                     is_long: in_long, killed: in_kill};

`ifdef COLLATE_FIFO_BYPASS_EN
  assign bypass = empty & in_valid & out_ready & ~in_kill;
`else
  assign bypass = 1'b0;
`endif

  // Killed heads drain on their own; the kill bit lands at the edge, so a
  // live head accepted in the kill cycle still pops normally.
  assign pop  = ~empty & (head.killed | out_ready);
  assign push = in_valid & ~bypass & (~full | pop);

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
      if (kill_valid && (mem_q[i].wfid == kill_wfid)) mem_d[i].killed = 1'b1;
    end
    if (push) mem_d[wr_ptr] = in_ent;
    ovf_d = ovf_q | (in_valid & ~bypass & full & ~pop);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      ovf_q <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
      ovf_q <= ovf_d;
    end
  end

  assign out_valid       = bypass | (~empty & ~head.killed);
  assign out_wfid        = bypass ? in_wfid  : head.wfid;
  assign out_instr       = bypass ? in_instr : head.instr;
  assign out_pc          = bypass ? in_pc    : head.pc;
  assign out_long        = bypass ? in_long  : head.is_long;
  assign out_count       = count;
  assign out_almost_full = almost_full;
  assign out_overflow    = ovf_q;
endmodule

// File: tb/tb_collate_decode_fifo.sv
// Scoreboard bench for collate_decode_fifo: a queue model checked every cycle.
module tb_collate_decode_fifo;
  localparam int DEPTH     = 4;
  localparam int AF_MARGIN = 1;
  localparam int CNT_W     = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_long, kill_valid, out_ready;
  logic [5:0]  in_wfid, kill_wfid;
  logic [63:0] in_instr;
  logic [31:0] in_pc;
  logic        out_valid, out_long, out_almost_full, out_overflow;
  logic [5:0]  out_wfid;
  logic [63:0] out_instr;
  logic [31:0] out_pc;
  logic [CNT_W-1:0] out_count;

  collate_decode_fifo #(.DEPTH(DEPTH), .AF_MARGIN(AF_MARGIN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_wfid(in_wfid), .in_instr(in_instr), .in_pc(in_pc),
    .in_long(in_long), .kill_valid(kill_valid), .kill_wfid(kill_wfid),
    .out_valid(out_valid), .out_ready(out_ready), .out_wfid(out_wfid),
    .out_instr(out_instr), .out_pc(out_pc), .out_long(out_long),
    .out_count(out_count), .out_almost_full(out_almost_full),
    .out_overflow(out_overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  w;
    logic [63:0] i;
    logic [31:0] p;
    logic        l;
    logic        k;
  } ment_t;

  ment_t mq[$];
  bit    ovf_m;
  int    total = 0;
  int    bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // One clock: drive at negedge, check just after, update model for the coming edge.
  task automatic cyc(input logic v, input logic [5:0] w, input logic [63:0] ins,
                     input logic [31:0] p, input logic l, input logic rdy,
                     input logic kv, input logic [5:0] kw);
    int  sz;
    bit  km, byp, expv, pop_m;
    @(negedge clk);
    in_valid = v; in_wfid = w; in_instr = ins; in_pc = p; in_long = l;
    out_ready = rdy; kill_valid = kv; kill_wfid = kw;
    #1;
    sz  = mq.size();
    km  = kv && (w == kw);
    byp = 1'b0;
`ifdef COLLATE_FIFO_BYPASS_EN
    byp = (sz == 0) && v && rdy && !km;
`endif
    chk("count", 64'(out_count), 64'(sz));
    chk("afull", 64'(out_almost_full), 64'(sz >= DEPTH - AF_MARGIN));
    chk("ovf", 64'(out_overflow), 64'(ovf_m));
    expv = byp || (sz != 0 && !mq[0].k);
    chk("valid", 64'(out_valid), 64'(expv));
    if (byp) begin
      chk("byp_wfid", 64'(out_wfid), 64'(w));
      chk("byp_pc", 64'(out_pc), 64'(p));
    end else if (expv && rdy) begin
      chk("wfid", 64'(out_wfid), 64'(mq[0].w));
      chk("instr", out_instr, mq[0].i);
      chk("pc", 64'(out_pc), 64'(mq[0].p));
      chk("long", 64'(out_long), 64'(mq[0].l));
    end
    pop_m = !byp && (sz != 0) && (mq[0].k || rdy);
    if (pop_m) void'(mq.pop_front());
    if (kv) foreach (mq[j]) if (mq[j].w == kw) mq[j].k = 1'b1;
    if (v && !byp) begin
      if (sz < DEPTH || pop_m) mq.push_back('{w, ins, p, l, km});
      else ovf_m = 1'b1;
    end
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) cyc(1'b0, 6'd0, 64'd0, 32'd0, 1'b0, rdy, 1'b0, 6'd0);
  endtask

  initial begin
    rst = 1'b0;
    in_valid = 0; in_wfid = 0; in_instr = 0; in_pc = 0; in_long = 0;
    out_ready = 0; kill_valid = 0; kill_wfid = 0;
    ovf_m = 1'b0;
    #2;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_count", 64'(out_count), 64'd0);
    chk("rst_afull", 64'(out_almost_full), 64'd0);
    chk("rst_ovf", 64'(out_overflow), 64'd0);
    chk("rst_instr", out_instr, 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // in-order delivery, long flag only on the second
    cyc(1, 6'd1, 64'h0000_0000_1111_0001, 32'h100, 0, 1, 0, 0);
    cyc(1, 6'd2, 64'hDEAD_BEEF_1234_5678, 32'h104, 1, 1, 0, 0);
    cyc(1, 6'd3, 64'h0000_0000_3333_0003, 32'h10C, 0, 1, 0, 0);
    idle(3, 1);

    // fill, overflow, then push+pop while full
    for (int k = 0; k < 5; k++)
      cyc(1, 6'(10 + k), 64'(k + 64'hA0), 32'(32'h200 + 4 * k), 0, 0, 0, 0);
    cyc(1, 6'd15, 64'hF0, 32'h214, 0, 1, 0, 0);
    idle(1, 0);
    idle(5, 1);

    // kill of wfid 5 while queued behind nothing
    cyc(1, 6'd5, 64'h55, 32'h300, 0, 0, 0, 0);
    cyc(1, 6'd7, 64'h77, 32'h304, 0, 0, 0, 0);
    cyc(1, 6'd5, 64'h56, 32'h308, 0, 0, 0, 0);
    cyc(1, 6'd9, 64'h99, 32'h30C, 0, 0, 0, 0);
    cyc(0, 6'd0, 64'h0, 32'h0, 0, 0, 1, 6'd5);
    idle(6, 1);

    // push killed in the same cycle
    cyc(1, 6'd4, 64'h44, 32'h400, 0, 1, 1, 6'd4);
    idle(3, 1);

    // kill of the head while it is being accepted
    cyc(1, 6'd20, 64'h20, 32'h500, 0, 0, 0, 0);
    cyc(1, 6'd21, 64'h21, 32'h504, 0, 0, 0, 0);
    cyc(0, 6'd0, 64'h0, 32'h0, 0, 1, 1, 6'd20);
    idle(3, 1);

    // wrap-around
    for (int k = 0; k < 10; k++)
      cyc(1, 6'(k), 64'(64'hC00 + k), 32'(4 * k), 0, 1, 0, 0);
    idle(3, 1);

    // asynchronous reset with two entries queued
    cyc(1, 6'd30, 64'h30, 32'h600, 0, 0, 0, 0);
    cyc(1, 6'd31, 64'h31, 32'h604, 0, 0, 0, 0);
    @(negedge clk);
    in_valid = 0;
    #2;
    rst = 1'b0;
    #1;
    chk("arst_valid", 64'(out_valid), 64'd0);
    chk("arst_count", 64'(out_count), 64'd0);
    chk("arst_ovf", 64'(out_overflow), 64'd0);
    mq.delete();
    ovf_m = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    idle(2, 1);

    // push into empty with ready (zero-latency only when bypass is built in)
    cyc(1, 6'd33, 64'h33, 32'h700, 0, 1, 0, 0);
    idle(3, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
